// File: rtl/mic1_mem_pkg.sv
// Shared types and constants for the MIC-1 memory-interface stage.
// Holds the channel state enums, latency-counter width and error-cause codes.
package mic1_mem_pkg;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_READ  = 2'd1,
    D_WRITE = 2'd2
  } d_state_t;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_WAIT = 1'b1
  } f_state_t;

  // Both channel FSMs live in one struct so checkers can bind to a single signal.
  typedef struct packed {
    d_state_t d_state;
    f_state_t f_state;
  } mem_state_t;

  localparam int CNT_W = $clog2(4);

  localparam int ERR_BOTH_STROBES = 0;
  localparam int ERR_OUT_OF_RANGE = 1;
  localparam int ERR_CAUSES       = 2;

  function automatic logic out_of_range(input logic [31:0] addr, input int aw);
    return (addr >> aw) != 32'd0;
  endfunction

endpackage

// File: rtl/mic1_mem_chan.sv
// Generic latency/capture channel: counts LAT edges after start, then captures
// rdata (or zero for a poisoned request) and pulses load for one cycle.
module mic1_mem_chan
  import mic1_mem_pkg::*;
#(
  parameter int W   = 32,
  parameter int LAT = 1   // legal 1..3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         zero,
  input  logic         run,
  input  logic [W-1:0] rdata,
  output logic         done,
  output logic [W-1:0] dout,
  output logic         load
);

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);

  logic [CNT_W-1:0] cnt;
  logic             zero_q;

  // done marks the capture edge, one edge after the counter reaches zero.
  assign done = run && (cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      zero_q <= 1'b0;
      dout   <= '0;
      load   <= 1'b0;
    end else begin
      load <= 1'b0;
      if (start) begin
        cnt    <= LAT_C;
        zero_q <= zero;
      end else if (done) begin
        dout <= zero_q ? '0 : rdata;
        load <= 1'b1;
      end else if (run) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mic1_mem_ctrl.sv
// MIC-1 memory-interface stage: turns READ/WRITE/FETCH strobes into timed
// RAM/ROM accesses and returns MDR/MBR load strobes, stalling via busy.
module mic1_mem_ctrl
  import mic1_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int PROG_ADDR_W = 12,
  parameter int RAM_LAT     = 1,
  parameter int ROM_LAT     = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rd,
  input  logic                   wr,
  input  logic                   fetch,
  input  logic [31:0]            mar,
  input  logic [31:0]            mdr_out,
  input  logic [31:0]            pc,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [31:0]            ram_wdata,
  output logic                   ram_wren,
  input  logic [31:0]            ram_rdata,
  output logic [PROG_ADDR_W-1:0] rom_addr,
  input  logic [7:0]             rom_rdata,
  output logic [31:0]            mdr_in,
  output logic                   mdr_load,
  output logic [7:0]             mbr_in,
  output logic                   mbr_load,
  output logic                   busy,
  output logic                   err
);

  // Handshake: a strobe is taken on the first rising edge at which its channel
  // is idle; the control path keeps MIR steady while busy, so nothing is queued.
  mem_state_t st, st_d;
  logic d_idle, f_idle, oor;
  logic rd_acc, wr_acc, both_acc, f_acc;
  logic rd_done, f_done;

  assign oor      = out_of_range(mar, ADDR_W);
  assign d_idle   = (st.d_state == D_IDLE);
  assign f_idle   = (st.f_state == F_IDLE);
  assign rd_acc   = d_idle && rd && !wr;
  assign wr_acc   = d_idle && wr && !rd;
  assign both_acc = d_idle && rd && wr;
  assign f_acc    = f_idle && fetch;
  assign busy     = !d_idle || !f_idle;

  always_comb begin
    st_d = st;
    case (st.d_state)
      D_IDLE: begin
        if (rd_acc)      st_d.d_state = D_READ;
        else if (wr_acc) st_d.d_state = D_WRITE;
      end
      D_READ:  if (rd_done) st_d.d_state = D_IDLE;
      D_WRITE: st_d.d_state = D_IDLE;
      default: st_d.d_state = D_IDLE;
    endcase
    case (st.f_state)
      F_IDLE:  if (f_acc) st_d.f_state = F_WAIT;
      F_WAIT:  if (f_done) st_d.f_state = F_IDLE;
      default: st_d.f_state = F_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) st <= '{d_state: D_IDLE, f_state: F_IDLE};
    else       st <= st_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wren  <= 1'b0;
      rom_addr  <= '0;
      err       <= 1'b0;
    end else begin
      ram_wren <= 1'b0;
      if (rd_acc || wr_acc) ram_addr <= mar[ADDR_W-1:0];
      if (wr_acc) begin
        ram_wdata <= mdr_out;
        // An out-of-range write still spends its D_WRITE cycle, just without the strobe.
        ram_wren  <= !oor;
      end
      if (f_acc) rom_addr <= pc[PROG_ADDR_W-1:0];
      if (both_acc || ((rd_acc || wr_acc) && oor)) err <= 1'b1;
    end
  end

  mic1_mem_chan #(.W(32), .LAT(RAM_LAT)) u_rd_chan (
    .clock (clock),
    .reset (reset),
    .start (rd_acc),
    .zero  (oor),
    .run   (st.d_state == D_READ),
    .rdata (ram_rdata),
    .done  (rd_done),
    .dout  (mdr_in),
    .load  (mdr_load)
  );

  mic1_mem_chan #(.W(8), .LAT(ROM_LAT)) u_fetch_chan (
    .clock (clock),
    .reset (reset),
    .start (f_acc),
    .zero  (1'b0),
    .run   (st.f_state == F_WAIT),
    .rdata (rom_rdata),
    .done  (f_done),
    .dout  (mbr_in),
    .load  (mbr_load)
  );

endmodule

// File: tb/tb_mic1_mem_ctrl.sv
// Self-checking bench for mic1_mem_ctrl: directed steps plus a randomized
// phase, scored against a word-level memory model and expected-value queues.
module tb_mic1_mem_ctrl;
  import mic1_mem_pkg::*;

  localparam int ADDR_W      = 10;
  localparam int PROG_ADDR_W = 12;
  localparam int RAM_LAT     = 1;
  localparam int ROM_LAT     = 1;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   rd = 1'b0, wr = 1'b0, fetch = 1'b0;
  logic [31:0]            mar = '0, mdr_out = '0, pc = '0;
  logic [ADDR_W-1:0]      ram_addr;
  logic [31:0]            ram_wdata;
  logic                   ram_wren;
  logic [31:0]            ram_rdata = '0;
  logic [PROG_ADDR_W-1:0] rom_addr;
  logic [7:0]             rom_rdata = '0;
  logic [31:0]            mdr_in;
  logic                   mdr_load;
  logic [7:0]             mbr_in;
  logic                   mbr_load;
  logic                   busy;
  logic                   err;

  mic1_mem_ctrl #(
    .ADDR_W(ADDR_W), .PROG_ADDR_W(PROG_ADDR_W), .RAM_LAT(RAM_LAT), .ROM_LAT(ROM_LAT)
  ) dut (
    .clock(clock), .reset(reset), .rd(rd), .wr(wr), .fetch(fetch),
    .mar(mar), .mdr_out(mdr_out), .pc(pc),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_rdata(ram_rdata),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .mdr_in(mdr_in), .mdr_load(mdr_load), .mbr_in(mbr_in), .mbr_load(mbr_load),
    .busy(busy), .err(err)
  );

  // ---------------- clock / memories ----------------
  always #5 clock = ~clock;

  logic [31:0] init_img [1024];
  logic [31:0] ram_mem  [1024];
  bit          ram_seen [1024];
  logic [7:0]  rom_mem  [4096];

  // One-cycle synchronous RAM/ROM: address sampled on an edge, data valid after it.
  always @(posedge clock) begin
    ram_rdata <= ram_seen[ram_addr] ? ram_mem[ram_addr] : init_img[ram_addr];
    if (ram_wren) begin
      ram_mem[ram_addr]  <= ram_wdata;
      ram_seen[ram_addr] <= 1'b1;
    end
    rom_rdata <= rom_mem[rom_addr];
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] ref_ram [1024];
  logic [31:0] exp_q[$];
  logic [7:0]  exp_b_q[$];
  logic        err_exp = 1'b0;
  int          total = 0, bad = 0;
  int          n_mdr_load = 0, n_mbr_load = 0, n_wren = 0;
  int          cov [ERR_CAUSES];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (mdr_load) begin
        n_mdr_load++;
        if (exp_q.size() == 0) check("mdr_load_unexpected", 32'd1, 32'd0);
        else check("mdr_in", mdr_in, exp_q.pop_front());
      end
      if (mbr_load) begin
        n_mbr_load++;
        if (exp_b_q.size() == 0) check("mbr_load_unexpected", 32'd1, 32'd0);
        else check("mbr_in", 32'(mbr_in), 32'(exp_b_q.pop_front()));
      end
      if (ram_wren) n_wren++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_zero(input string tag);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_wdata"}, ram_wdata, 32'd0);
    check({tag, "_ram_wren"}, 32'(ram_wren), 32'd0);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_mdr_in"}, mdr_in, 32'd0);
    check({tag, "_mdr_load"}, 32'(mdr_load), 32'd0);
    check({tag, "_mbr_in"}, 32'(mbr_in), 32'd0);
    check({tag, "_mbr_load"}, 32'(mbr_load), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_zero("rst");
    @(negedge clock);
    reset   = 1'b0;
    err_exp = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr);
    logic        oor;
    logic [31:0] e;
    int          lat;
    oor = (addr >> ADDR_W) != 0;
    e   = oor ? 32'd0 : ref_ram[addr[ADDR_W-1:0]];
    if (oor) begin err_exp = 1'b1; cov[ERR_OUT_OF_RANGE]++; end
    exp_q.push_back(e);
    @(negedge clock);
    mar = addr; rd = 1'b1;
    @(negedge clock);
    rd = 1'b0;
    check("rd_busy", 32'(busy), 32'd1);
    check("rd_ram_addr", 32'(ram_addr), 32'(addr[ADDR_W-1:0]));
    lat = 1;
    while (!mdr_load && lat < 12) begin @(negedge clock); lat++; end
    check("rd_latency", lat, RAM_LAT + 2);
    check("rd_busy_end", 32'(busy), 32'd0);
    check("rd_err", 32'(err), 32'(err_exp));
    @(negedge clock);
    check("rd_pulse_width", 32'(mdr_load), 32'd0);
    check("mdr_hold", mdr_in, e);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    logic oor;
    int   w0;
    oor = (addr >> ADDR_W) != 0;
    if (oor) begin err_exp = 1'b1; cov[ERR_OUT_OF_RANGE]++; end
    w0 = n_wren;
    @(negedge clock);
    mar = addr; mdr_out = data; wr = 1'b1;
    @(negedge clock);
    wr = 1'b0;
    check("wr_busy", 32'(busy), 32'd1);
    check("wr_wren", 32'(ram_wren), 32'(!oor));
    if (!oor) begin
      check("wr_addr", 32'(ram_addr), 32'(addr[ADDR_W-1:0]));
      check("wr_data", ram_wdata, data);
    end
    @(negedge clock);
    check("wr_wren_drop", 32'(ram_wren), 32'd0);
    check("wr_busy_end", 32'(busy), 32'd0);
    check("wr_err", 32'(err), 32'(err_exp));
    check("wr_pulses", n_wren - w0, oor ? 0 : 1);
    if (!oor) ref_ram[addr[ADDR_W-1:0]] = data;
  endtask

  task automatic do_fetch(input logic [31:0] p);
    int lat;
    exp_b_q.push_back(rom_mem[p[PROG_ADDR_W-1:0]]);
    @(negedge clock);
    pc = p; fetch = 1'b1;
    @(negedge clock);
    fetch = 1'b0;
    check("f_busy", 32'(busy), 32'd1);
    check("f_rom_addr", 32'(rom_addr), 32'(p[PROG_ADDR_W-1:0]));
    lat = 1;
    while (!mbr_load && lat < 12) begin @(negedge clock); lat++; end
    check("f_latency", lat, ROM_LAT + 2);
    @(negedge clock);
    check("f_pulse_width", 32'(mbr_load), 32'd0);
  endtask

  task automatic do_pair(input logic [31:0] addr, input logic [31:0] p);
    int lat;
    exp_q.push_back(ref_ram[addr[ADDR_W-1:0]]);
    exp_b_q.push_back(rom_mem[p[PROG_ADDR_W-1:0]]);
    @(negedge clock);
    mar = addr; rd = 1'b1; pc = p; fetch = 1'b1;
    @(negedge clock);
    rd = 1'b0; fetch = 1'b0;
    check("pair_busy", 32'(busy), 32'd1);
    lat = 1;
    while (!mdr_load && lat < 12) begin @(negedge clock); lat++; end
    check("pair_latency", lat, RAM_LAT + 2);
    check("pair_mbr_same_cycle", 32'(mbr_load), 32'd1);
    @(negedge clock);
    check("pair_busy_end", 32'(busy), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int          l0, w0;
    logic [31:0] a, d;
    for (int i = 0; i < 1024; i++) begin
      init_img[i] = $urandom();
      ref_ram[i]  = init_img[i];
    end
    init_img[5] = 32'hDEADBEEF; ref_ram[5] = 32'hDEADBEEF;
    init_img[2] = 32'h1;        ref_ram[2] = 32'h1;
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom());
    rom_mem[3] = 8'hA7;
    for (int i = 0; i < ERR_CAUSES; i++) cov[i] = 0;

    repeat (2) @(negedge clock);
    check_zero("por");
    reset = 1'b0;

    do_read(32'h5);
    do_write(32'h7, 32'h12345678);
    do_read(32'h7);
    do_pair(32'h2, 32'h3);
    do_fetch(32'($urandom_range(0, 4095)));

    // Both strobes: nothing happens except the sticky error.
    l0 = n_mdr_load; w0 = n_wren;
    @(negedge clock);
    mar = 32'h5; rd = 1'b1; wr = 1'b1;
    @(negedge clock);
    rd = 1'b0; wr = 1'b0; cov[ERR_BOTH_STROBES]++;
    check("both_wren", 32'(ram_wren), 32'd0);
    check("both_busy", 32'(busy), 32'd0);
    check("both_err", 32'(err), 32'd1);
    repeat (10) @(negedge clock);
    check("both_err_sticky", 32'(err), 32'd1);
    check("both_no_load", n_mdr_load - l0, 0);
    check("both_no_wren", n_wren - w0, 0);
    do_reset();

    do_read(32'h400);
    do_write(32'h400, 32'hCAFEF00D);
    do_read(32'h0);
    do_reset();

    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 7) == 0) ? ($urandom() | 32'h400) : 32'($urandom_range(0, 1023));
      d = $urandom();
      case ($urandom_range(0, 3))
        0: do_read(a);
        1: do_write(a, d);
        2: do_fetch(32'($urandom()));
        default: do_pair(32'($urandom_range(0, 1023)), 32'($urandom()));
      endcase
    end
    do_reset();

    // Reset in the middle of a write drops the strobe and leaves RAM untouched.
    @(negedge clock);
    mar = 32'h3; mdr_out = ~ref_ram[3]; wr = 1'b1;
    @(negedge clock);
    wr = 1'b0;
    check("rw_wren_before", 32'(ram_wren), 32'd1);
    #2 reset = 1'b1;
    #1 check_zero("rst_mid_write");
    @(negedge clock);
    reset = 1'b0; err_exp = 1'b0;
    do_read(32'h3);

    // rd held for six edges gives exactly two reads.
    exp_q.push_back(ref_ram[17]);
    exp_q.push_back(ref_ram[17]);
    l0 = n_mdr_load;
    @(negedge clock);
    mar = 32'd17; rd = 1'b1;
    repeat (6) @(negedge clock);
    rd = 1'b0;
    repeat (4) @(negedge clock);
    check("held_rd_count", n_mdr_load - l0, 2);
    check("held_rd_idle", 32'(busy), 32'd0);

    // Reset in the middle of a read abandons it.
    @(negedge clock);
    mar = 32'h2A; rd = 1'b1;
    @(negedge clock);
    rd = 1'b0;
    check("rr_busy_before", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1 check_zero("rst_mid_read");
    @(negedge clock);
    reset = 1'b0; err_exp = 1'b0;
    l0 = n_mdr_load;
    repeat (5) @(negedge clock);
    check("rr_no_load", n_mdr_load - l0, 0);

    check("mdr_queue_drained", 32'(exp_q.size()), 32'd0);
    check("mbr_queue_drained", 32'(exp_b_q.size()), 32'd0);
    $display("err causes exercised: both=%0d range=%0d", cov[ERR_BOTH_STROBES], cov[ERR_OUT_OF_RANGE]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
